rvv_backend_pmtrdt_dispatch: RTL
================================

RVV_BACKEND_PMTRDT_DISPATCH -- requirements
Module: rvv_backend_pmtrdt_dispatch

Interface
REQ-001 SHALL have parameter NUM_UNIT, default 2, number of PMTRDT execution units (legal 1..4).
REQ-002 SHALL have parameter NUM_PORT, default 2, number of ROB write ports (legal 1..NUM_UNIT).
REQ-003 SHALL have parameter ORD_DEPTH, default 8, order-queue entries (power of 2, >=2).
REQ-004 SHALL have parameter UOP_W, default 128, uop payload width.
REQ-005 SHALL have parameter RES_W, default 160, result payload width.
REQ-006 SHALL have port clk  input  1  the single clock; all state is rising-edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port rs_valid  input  1  RS FIFO head holds a uop.
REQ-009 SHALL have port rs_uop  input  UOP_W  RS head uop payload.
REQ-010 SHALL have port rs_special  input  1  head uop is compare/reduction/compress and must run on unit 0.
REQ-011 SHALL have port rs_pop  output  1  head uop consumed this cycle.
REQ-012 SHALL have ports unit_valid / unit_uop / unit_ready  output / output / input  NUM_UNIT / NUM_UNIT*UOP_W / NUM_UNIT  issue handshake per unit.
REQ-013 SHALL have ports unit_res_valid / unit_res / unit_res_ready  input / input / output  NUM_UNIT / NUM_UNIT*RES_W / NUM_UNIT  result handshake per unit.
REQ-014 SHALL have ports rob_valid / rob_res / rob_ready  output / output / input  NUM_PORT / NUM_PORT*RES_W / NUM_PORT  ROB write ports.
REQ-015 SHALL have port busy  output  1  order queue non-empty.

Function
REQ-016 SHALL issue at most one uop per cycle; issue occurs when rs_valid=1, order queue not full, and the selected unit's unit_ready=1.
REQ-017 SHALL select unit 0 when rs_special=1; otherwise the first unit with unit_ready=1 searching upward (wrapping) from rr_ptr.
REQ-018 SHALL assert unit_valid only on the selected unit, only when issue occurs, with unit_uop[sel]=rs_uop; issue path has zero-cycle latency (combinational).
REQ-019 SHALL assert rs_pop exactly in cycles where issue occurs.
REQ-020 SHALL update rr_ptr to (sel+1) mod NUM_UNIT on each non-special issue; special issues leave rr_ptr unchanged.
REQ-021 SHALL hold a special head uop (no issue, no bypass by younger uops) while unit 0 is not ready, even if other units are ready.
REQ-022 SHALL push the selected unit index into the order queue on issue; queue full (ORD_DEPTH entries) blocks issue.
REQ-023 SHALL retire results in issue order: ROB port k carries order-queue entry head+k.
REQ-024 SHALL assert rob_valid[k] iff entry head+k exists, its unit has unit_res_valid=1, rob_valid[j]=1 and rob_ready[j]=1 for all j<k, and no entry head+j (j<k) names the same unit.
REQ-025 SHALL drive rob_res[k] = unit_res of the unit in entry head+k; rob_res is don't-care when rob_valid[k]=0.
REQ-026 SHALL retire count n = number of leading ports with rob_valid&rob_ready; pop n entries and assert unit_res_ready for exactly those n units.
REQ-027 SHALL support simultaneous issue and retire in one cycle, including on a full queue (retire frees space next cycle only; no same-cycle full bypass) and on an empty queue (no retire).
REQ-028 SHALL ignore unit_res_valid from a unit not named by any of the first NUM_PORT queue entries (no unit_res_ready).
REQ-029 SHALL keep order-queue pointers as log2(ORD_DEPTH)-bit wrap-around indices plus a count 0..ORD_DEPTH.
REQ-030 SHALL drive busy = (count != 0).

Reset
REQ-031 SHALL on rst=1, asynchronously clear order queue (count=0, head=tail=0), rr_ptr=0.
REQ-032 SHALL force rs_pop, unit_valid, unit_res_ready, rob_valid, busy to 0 while rst=1, including reset mid-operation; in-flight results are abandoned.

Verification
REQ-033 SHALL cover: NUM_UNIT=2, three non-special uops, both units ready -> issued to units 0,1,0 on consecutive cycles, rr_ptr=1 after.
REQ-034 SHALL cover: special head, unit 0 not ready for 3 cycles, unit 1 ready -> rs_pop=0 for 3 cycles, then issue to unit 0.
REQ-035 SHALL cover: uops A->u0, B->u1, u1 result returns 2 cycles before u0 -> rob_valid[0]=0 until u0 valid, then A on port 0 and B on port 1 same cycle.
REQ-036 SHALL cover: ORD_DEPTH=8, no results returned -> exactly 8 issues, then rs_pop=0; one retire -> one further issue next cycle.
REQ-037 SHALL cover: rob_ready=2'b01 with two retirable entries -> only port 0 retires, port 1 entry retires next cycle.
REQ-038 SHALL cover: rst asserted with 5 entries outstanding -> busy=0 and all valids 0 immediately, first post-reset issue goes to unit 0.

Source files
------------

// File: rtl/rvv_backend_pmtrdt_dispatch.sv
// ----------------------------------------------------------------------------
// rvv_backend_pmtrdt_dispatch
//
// Issues uops from the PMTRDT reservation-station head to one of NUM_UNIT
// execution units and retires their results to the ROB in issue order.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rs_valid/rs_uop     RS head uop and its payload
//   rs_special          head must run on unit 0 (compare/reduction/compress)
//   rs_pop              head consumed this cycle
//   unit_valid/uop/ready        per-unit issue handshake
//   unit_res_valid/res/ready    per-unit result handshake
//   rob_valid/rob_res/rob_ready NUM_PORT in-order ROB write ports
//   busy                order queue holds at least one outstanding uop
// ----------------------------------------------------------------------------
module rvv_backend_pmtrdt_dispatch #(
    parameter int NUM_UNIT  = 2,
    parameter int NUM_PORT  = 2,
    parameter int ORD_DEPTH = 8,
    parameter int UOP_W     = 128,
    parameter int RES_W     = 160
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rs_valid,
    input  logic [UOP_W-1:0]          rs_uop,
    input  logic                      rs_special,
    output logic                      rs_pop,
    output logic [NUM_UNIT-1:0]       unit_valid,
    output logic [NUM_UNIT*UOP_W-1:0] unit_uop,
    input  logic [NUM_UNIT-1:0]       unit_ready,
    input  logic [NUM_UNIT-1:0]       unit_res_valid,
    input  logic [NUM_UNIT*RES_W-1:0] unit_res,
    output logic [NUM_UNIT-1:0]       unit_res_ready,
    output logic [NUM_PORT-1:0]       rob_valid,
    output logic [NUM_PORT*RES_W-1:0] rob_res,
    input  logic [NUM_PORT-1:0]       rob_ready,
    output logic                      busy
);

    localparam int UW = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;
    localparam int PW = $clog2(ORD_DEPTH);
    localparam int CW = $clog2(ORD_DEPTH + 1);

    // Order queue: unit index of each outstanding uop, oldest at head.
    logic [UW-1:0] ord_q [ORD_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [UW-1:0] rr_ptr;

    logic          q_full;
    logic          found;
    logic          issue;
    logic [UW-1:0] sel;
    logic [UW-1:0] cand;

    logic [UW-1:0] ent_unit [NUM_PORT];
    logic          chain;
    logic          dup;
    logic [CW-1:0] n_ret;

    // ------------------------------------------------------------------
    // Issue selection. A special head waits for unit 0 and blocks the RS
    // (no younger uop may bypass it); otherwise round-robin from rr_ptr.
    // ------------------------------------------------------------------
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        if (rs_special) begin
            found = unit_ready[0];
        end else begin
            for (int unsigned i = 0; i < NUM_UNIT; i++) begin
                cand = UW'((32'(rr_ptr) + i) % NUM_UNIT);
                if (!found && unit_ready[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
        q_full = (count == CW'(ORD_DEPTH));
        issue  = rs_valid && found && !q_full && !rst;
    end

    always_comb begin
        unit_valid = '0;
        if (issue) begin
            unit_valid[sel] = 1'b1;
        end
    end

    assign unit_uop = {NUM_UNIT{rs_uop}};
    assign rs_pop   = issue;

    // ------------------------------------------------------------------
    // In-order retirement. Port k may only fire if every older port fires
    // this cycle, and a unit can feed at most one port per cycle since it
    // presents only its oldest result.
    // ------------------------------------------------------------------
    always_comb begin
        rob_valid      = '0;
        rob_res        = '0;
        unit_res_ready = '0;
        n_ret          = '0;
        chain          = !rst;
        dup            = 1'b0;
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            ent_unit[k] = ord_q[head + PW'(k)];
            dup = 1'b0;
            for (int unsigned j = 0; j < k; j++) begin
                if (ent_unit[j] == ent_unit[k]) begin
                    dup = 1'b1;
                end
            end
            rob_valid[k] = chain && (CW'(k) < count) &&
                           unit_res_valid[ent_unit[k]] && !dup;
            rob_res[k*RES_W +: RES_W] = unit_res[ent_unit[k]*RES_W +: RES_W];
            if (rob_valid[k] && rob_ready[k]) begin
                unit_res_ready[ent_unit[k]] = 1'b1;
                n_ret = n_ret + 1'b1;
            end
            chain = rob_valid[k] && rob_ready[k];
        end
    end

    assign busy = (count != '0) && !rst;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (issue) begin
                tail <= tail + 1'b1;
                if (!rs_special) begin
                    rr_ptr <= (sel == UW'(NUM_UNIT - 1)) ? '0 : sel + 1'b1;
                end
            end
            head  <= head + PW'(n_ret);
            count <= count + CW'(issue) - n_ret;
        end
    end

    // Storage needs no reset: entries are only read below count.
    always_ff @(posedge clk) begin
        if (issue) begin
            ord_q[tail] <= sel;
        end
    end

endmodule
